debug_mem_port: RTL
===================

// Module: debug_mem_port
// PURPOSE
//  Memory-side responder for the debug controller's imem/dmem request strobes.
//  Sits between one CPU memory port and its memory and arbitrates CPU vs debug access.
//  Performs the debug read or write over a req/ack memory handshake.
//  Returns read data with a 1-cycle data_ready pulse.
//  One instance is used per memory (imem, dmem). All logic is in the CPU clock domain.
// PARAMETERS
//  ADDR_W   64    address width, all ports
//  DATA_W   64    data width, all ports
//  TIMEOUT  1023  max cycles waiting for mem_ack before a debug access aborts; must be >=1
// PORTS
//  clk              in   1       CPU clock; everything is sampled on its rising edge
//  rst_p            in   1       synchronous reset, active-high
//  dbg_ce           in   1       1-cycle request strobe from the debug controller
//  dbg_we           in   1       qualifies dbg_ce: 1=write, 0=read
//  dbg_addr         in   ADDR_W  debug address; sampled only when dbg_ce=1
//  dbg_wdata        in   DATA_W  debug write data; sampled only when dbg_ce=1
//  dbg_rdata        out  DATA_W  debug read data; valid while dbg_rdata_ready=1
//  dbg_rdata_ready  out  1       1-cycle pulse at the end of every debug read
//  dbg_timeout      out  1       1-cycle pulse when a debug access aborts on timeout
//  dbg_overrun      out  1       sticky; set when dbg_ce arrives while a debug access is pending
//  cpu_req          in   1       CPU access request; held high until cpu_ack
//  cpu_we           in   1       CPU write enable
//  cpu_addr         in   ADDR_W  CPU address
//  cpu_wdata        in   DATA_W  CPU write data
//  cpu_rdata        out  DATA_W  = mem_rdata (combinational)
//  cpu_ack          out  1       = mem_ack & (state==CPU_XFER) (combinational)
//  cpu_stall        out  1       1 while debug owns the port or a debug access is pending
//  mem_req          out  1       memory request; held high until the mem_ack cycle
//  mem_we           out  1       memory write enable
//  mem_addr         out  ADDR_W  memory address
//  mem_wdata        out  DATA_W  memory write data
//  mem_rdata        in   DATA_W  memory read data; valid when mem_ack=1
//  mem_ack          in   1       1-cycle completion pulse from memory
// BEHAVIOUR
//  - Reset values: all outputs are 0, state=IDLE, pending flag=0, timeout counter=0.
//  - Reset mid-access: the access is dropped and mem_req=0 on the next edge.
//  - States:
//    IDLE:     dbg_ce=1 or pending=1 -> latch op/addr/wdata, mem_req<=1, DBG_XFER
//              (debug wins over a simultaneous cpu_req).
//              else cpu_req=1 -> register the cpu_* fields onto mem_*, mem_req<=1, CPU_XFER.
//    CPU_XFER: on mem_ack: mem_req<=0, cpu_ack=1 that cycle, -> IDLE.
//              dbg_ce here -> set pending; it is served on the return to IDLE.
//    DBG_XFER: on mem_ack: mem_req<=0, capture mem_rdata into dbg_rdata, -> DBG_RESP.
//              on counter==TIMEOUT: mem_req<=0, dbg_rdata<=0, -> DBG_RESP with the timeout flag.
//    DBG_RESP: one cycle. dbg_rdata_ready=1 if the op was a read.
//              dbg_timeout=1 if the op aborted.
//              -> IDLE.
//  - Timeout counter: clears on entry to DBG_XFER and increments each DBG_XFER cycle.
//    It saturates and never wraps. CPU accesses have no timeout.
//  - Latency: dbg_ce at edge N in IDLE -> mem_req=1 at N+1.
//    mem_ack at edge M -> dbg_rdata_ready=1 at M+1 -> IDLE at M+2.
//  - mem_req deasserts in the cycle after the mem_ack cycle. A new request needs at
//    least one cycle with mem_req=0 (back-to-back requests are spaced by IDLE).
//  - Pending: holds one request. dbg_ce while pending=1 or in DBG_XFER/DBG_RESP ->
//    the request is ignored and dbg_overrun<=1. dbg_overrun clears only on rst_p.
//  - A debug write never pulses dbg_rdata_ready; it completes silently.
//  - cpu_stall = pending | (state in DBG_XFER, DBG_RESP).
//    cpu_ack never pulses outside CPU_XFER. mem_ack outside an XFER state is ignored.
//  - Write ordering: each write is presented at most once; retries are the
//    initiator's job.
// TESTING
//  1. dbg_ce=1, we=0, addr=0x40 in IDLE; mem_ack 3 cycles later with rdata=0xDEADBEEF
//     -> one mem_req burst at addr 0x40, we=0; then dbg_rdata_ready=1 with rdata=0xDEADBEEF.
//  2. dbg write addr=0x8, wdata=0x1234 -> mem_we=1, mem_wdata=0x1234;
//     dbg_rdata_ready stays 0 throughout.
//  3. cpu_req in flight (CPU_XFER) + dbg_ce -> cpu_stall=1; cpu_ack on its mem_ack;
//     the debug read then issues.
//  4. dbg_ce and cpu_req on the same edge in IDLE -> debug served first;
//     CPU access follows after DBG_RESP.
//  5. TIMEOUT=4, mem_ack never arrives -> mem_req drops after 4 cycles;
//     dbg_timeout=1 and dbg_rdata_ready=1 with rdata=0.
//  6. Three dbg_ce pulses during one CPU_XFER -> one pending served, dbg_overrun=1;
//     rst_p clears it and mem_req.

Source files
------------

// File: rtl/debug_mem_port.sv
// Debug/CPU arbiter in front of one memory port: serves debug controller
// read/write strobes over the mem req/ack handshake, with timeout and overrun.
module debug_mem_port #(
   parameter int ADDR_W  = 64,
   parameter int DATA_W  = 64,
   parameter int TIMEOUT = 1023
) (
   input  logic              i_clk,
   input  logic              i_rst_p,
   input  logic              i_dbg_ce,
   input  logic              i_dbg_we,
   input  logic [ADDR_W-1:0] i_dbg_addr,
   input  logic [DATA_W-1:0] i_dbg_wdata,
   output logic [DATA_W-1:0] o_dbg_rdata,
   output logic              o_dbg_rdata_ready,
   output logic              o_dbg_timeout,
   output logic              o_dbg_overrun,
   input  logic              i_cpu_req,
   input  logic              i_cpu_we,
   input  logic [ADDR_W-1:0] i_cpu_addr,
   input  logic [DATA_W-1:0] i_cpu_wdata,
   output logic [DATA_W-1:0] o_cpu_rdata,
   output logic              o_cpu_ack,
   output logic              o_cpu_stall,
   output logic              o_mem_req,
   output logic              o_mem_we,
   output logic [ADDR_W-1:0] o_mem_addr,
   output logic [DATA_W-1:0] o_mem_wdata,
   input  logic [DATA_W-1:0] i_mem_rdata,
   input  logic              i_mem_ack
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_CPU  = 2'd1;
   localparam logic [1:0] S_DBG  = 2'd2;
   localparam logic [1:0] S_RESP = 2'd3;

   localparam int CNT_W = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT);

   logic [1:0]        r_state;
   logic              r_pend;
   logic              r_pend_we;
   logic [ADDR_W-1:0] r_pend_addr;
   logic [DATA_W-1:0] r_pend_wdata;
   logic [CNT_W-1:0]  r_cnt;
   logic              r_timed_out;
   logic              r_overrun;
   logic [DATA_W-1:0] r_dbg_rdata;
   logic              r_mem_req;
   logic              r_mem_we;
   logic [ADDR_W-1:0] r_mem_addr;
   logic [DATA_W-1:0] r_mem_wdata;

   logic [CNT_W-1:0]  w_cnt_nxt;
   logic              w_in_dbg;

   // Count of DBG_XFER cycles including the current one; saturates at TIMEOUT.
   assign w_cnt_nxt = (r_cnt == TO_VAL) ? r_cnt : r_cnt + CNT_W'(1);
   assign w_in_dbg  = (r_state == S_DBG) || (r_state == S_RESP);

   always_ff @(posedge i_clk) begin
      if (i_rst_p) begin
         r_state      <= S_IDLE;
         r_pend       <= 1'b0;
         r_pend_we    <= 1'b0;
         r_pend_addr  <= '0;
         r_pend_wdata <= '0;
         r_cnt        <= '0;
         r_timed_out  <= 1'b0;
         r_overrun    <= 1'b0;
         r_dbg_rdata  <= '0;
         r_mem_req    <= 1'b0;
         r_mem_we     <= 1'b0;
         r_mem_addr   <= '0;
         r_mem_wdata  <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (r_pend) begin
                  r_pend      <= 1'b0;
                  r_mem_we    <= r_pend_we;
                  r_mem_addr  <= r_pend_addr;
                  r_mem_wdata <= r_pend_wdata;
                  r_mem_req   <= 1'b1;
                  r_cnt       <= '0;
                  r_state     <= S_DBG;
                  if (i_dbg_ce) r_overrun <= 1'b1;
               end else if (i_dbg_ce) begin
                  r_mem_we    <= i_dbg_we;
                  r_mem_addr  <= i_dbg_addr;
                  r_mem_wdata <= i_dbg_wdata;
                  r_mem_req   <= 1'b1;
                  r_cnt       <= '0;
                  r_state     <= S_DBG;
               end else if (i_cpu_req) begin
                  r_mem_we    <= i_cpu_we;
                  r_mem_addr  <= i_cpu_addr;
                  r_mem_wdata <= i_cpu_wdata;
                  r_mem_req   <= 1'b1;
                  r_state     <= S_CPU;
               end
            end
            S_CPU: begin
               if (i_dbg_ce) begin
                  if (r_pend) begin
                     r_overrun <= 1'b1;
                  end else begin
                     r_pend       <= 1'b1;
                     r_pend_we    <= i_dbg_we;
                     r_pend_addr  <= i_dbg_addr;
                     r_pend_wdata <= i_dbg_wdata;
                  end
               end
               if (i_mem_ack) begin
                  r_mem_req <= 1'b0;
                  r_state   <= S_IDLE;
               end
            end
            S_DBG: begin
               if (i_dbg_ce) r_overrun <= 1'b1;
               if (i_mem_ack) begin
                  r_mem_req   <= 1'b0;
                  r_dbg_rdata <= i_mem_rdata;
                  r_timed_out <= 1'b0;
                  r_state     <= S_RESP;
               end else if (w_cnt_nxt == TO_VAL) begin
                  r_mem_req   <= 1'b0;
                  r_dbg_rdata <= '0;
                  r_timed_out <= 1'b1;
                  r_state     <= S_RESP;
               end else begin
                  r_cnt <= w_cnt_nxt;
               end
            end
            S_RESP: begin
               if (i_dbg_ce) r_overrun <= 1'b1;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // The debug op type stays visible on mem_we through the response cycle.
   assign o_dbg_rdata_ready = (r_state == S_RESP) && !r_mem_we;
   assign o_dbg_timeout     = (r_state == S_RESP) && r_timed_out;
   assign o_dbg_rdata       = r_dbg_rdata;
   assign o_dbg_overrun     = r_overrun;
   assign o_cpu_rdata       = i_mem_rdata;
   assign o_cpu_ack         = i_mem_ack && (r_state == S_CPU);
   assign o_cpu_stall       = r_pend || w_in_dbg;
   assign o_mem_req         = r_mem_req;
   assign o_mem_we          = r_mem_we;
   assign o_mem_addr        = r_mem_addr;
   assign o_mem_wdata       = r_mem_wdata;

endmodule
